// File: rtl/hazard_pkg.sv
// Shared constants and elaboration helpers for the load-use hazard scoreboard.
package hazard_pkg;

  localparam int ZERO_REG     = 0;
  localparam int LOAD_LAT_MAX = 4;

  // Counter width needed to hold LOAD_LAT-1, never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return ($clog2(lat) < 1) ? 1 : $clog2(lat);
  endfunction

  function automatic bit lat_in_range(input int lat);
    return (lat >= 1) && (lat <= LOAD_LAT_MAX);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown of cycles until an in-flight load result is forwardable.
module hazard_sb_entry #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [CW-1:0] reload,
  output logic          busy
);

  logic [CW-1:0] cnt_r;

  // A fresh issue reloads the count; otherwise drain toward ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (issue) begin
      cnt_r <= reload;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != {CW{1'b0}});

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit between ID and EX with a per-register load-latency scoreboard.
module load_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_reg_write_addr,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              branch_flush,
  output logic              stall,
  output logic              pc_ifwrite,
  output logic [PERF_W-1:0] stall_count
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CW    = cnt_width(LOAD_LAT);
  localparam logic [CW-1:0]     RELOAD    = CW'(LOAD_LAT - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  if (!lat_in_range(LOAD_LAT)) begin : g_lat_check
    $error("load_hazard_scoreboard: LOAD_LAT must be 1..%0d", LOAD_LAT_MAX);
  end

  logic              ex_load_s;
  logic [NREGS-1:0]  issue_s;
  logic [NREGS-1:0]  busy_s;
  logic              rs_busy_s;
  logic              rt_busy_s;
  logic              stall_s;
  logic [PERF_W-1:0] stall_count_r;

  assign ex_load_s = ex_valid & ex_mem_read & (ex_reg_write_addr != ZERO_ADDR);

  for (genvar i = 0; i < NREGS; i++) begin : g_sb
    assign issue_s[i] = ex_load_s & (ex_reg_write_addr == ADDR_W'(i));
    hazard_sb_entry #(.CW(CW)) u_entry (
      .clk    (clk),
      .rst    (rst),
      .issue  (issue_s[i]),
      .reload (RELOAD),
      .busy   (busy_s[i])
    );
  end

  // Operand read ports: the EX-stage match covers the issue cycle, the counter covers the rest.
  always_comb begin
    rs_busy_s = (id_rs_addr != ZERO_ADDR) & (issue_s[id_rs_addr] | busy_s[id_rs_addr]);
    rt_busy_s = (id_rt_addr != ZERO_ADDR) & (issue_s[id_rt_addr] | busy_s[id_rt_addr]);
    stall_s   = id_valid & ~branch_flush & ~rst &
                ((id_uses_rs & rs_busy_s) | (id_uses_rt & rt_busy_s));
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_r <= {PERF_W{1'b0}};
    end else if (stall_s && (stall_count_r != {PERF_W{1'b1}})) begin
      stall_count_r <= stall_count_r + PERF_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall       = stall_s;
  assign pc_ifwrite  = ~stall_s;
  assign stall_count = stall_count_r;

endmodule
